// File: rtl/fx_kport_if.sv
// KPC register-side bus of one K-Port transceiver: start controls and pad word,
// plus the status/data that software reads back.
interface fx_kport_if;
   logic        TRG;
   logic        MOD;
   logic        IOS;
   logic [31:0] TXD;
   logic        RD_ACK;
   logic [31:0] RXD;
   logic        BUSY;
   logic        END;
   logic        KINT;

   modport master (output TRG, MOD, IOS, TXD, RD_ACK, input RXD, BUSY, END, KINT);
   modport slave  (input TRG, MOD, IOS, TXD, RD_ACK, output RXD, BUSY, END, KINT);
endinterface

// File: rtl/fx_kport.sv
// PC-FX K-Port serial transceiver: latch/clock/data protocol for one pad port.
// FX_KPORT_INT_EN enables the one-tick KINT pulse; otherwise KINT is tied low.
module fx_kport #(
   parameter int HALF = 4,
   parameter int BITS = 32
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   fx_kport_if.slave   kpc,
   output logic        KP_LATCH,
   output logic        KP_CLK,
   input  logic        KP_DI,
   output logic        KP_DO,
   output logic        KP_OE
);
   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] LATCH    = 3'd1;
   localparam logic [2:0] SHIFT_LO = 3'd2;
   localparam logic [2:0] SHIFT_HI = 3'd3;
   localparam logic [2:0] DONE     = 3'd4;

   localparam logic [7:0] HALF_M1 = 8'(HALF - 1);
   localparam logic [4:0] LAST    = 5'(BITS - 1);

   logic [2:0]  state;
   logic [7:0]  cnt;
   logic [4:0]  bit_idx;
   logic        ios_c;
   logic [31:0] txd_c;
   logic [31:0] sr;
   logic [31:0] rxd;
   logic        end_f;
   logic        busy;
   logic        shifting;

   always_ff @(posedge CLK) begin
      if (!RESn) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         ios_c   <= 1'b0;
         txd_c   <= '0;
         sr      <= '0;
         rxd     <= '0;
         end_f   <= 1'b0;
      end else if (CE) begin
         // DONE's set below follows this clear, so set wins on a collision
         if (kpc.RD_ACK) end_f <= 1'b0;
         case (state)
            IDLE: if (kpc.TRG) begin
               ios_c   <= kpc.IOS;
               txd_c   <= kpc.TXD;
               sr      <= '0;
               bit_idx <= '0;
               cnt     <= HALF_M1;
               state   <= kpc.MOD ? LATCH : SHIFT_LO;
            end
            // Latch spans two halves; bit_idx[0] marks the second half so the
            // 8-bit phase counter only ever holds HALF-1.
            LATCH: if (cnt == '0) begin
               cnt <= HALF_M1;
               if (bit_idx[0]) begin
                  bit_idx <= '0;
                  state   <= SHIFT_LO;
               end else begin
                  bit_idx <= 5'd1;
               end
            end else begin
               cnt <= cnt - 8'd1;
            end
            SHIFT_LO: if (cnt == '0) begin
               cnt         <= HALF_M1;
               sr[bit_idx] <= KP_DI;
               state       <= SHIFT_HI;
            end else begin
               cnt <= cnt - 8'd1;
            end
            SHIFT_HI: if (cnt == '0) begin
               cnt <= HALF_M1;
               if (bit_idx == LAST) begin
                  state <= DONE;
               end else begin
                  bit_idx <= bit_idx + 5'd1;
                  state   <= SHIFT_LO;
               end
            end else begin
               cnt <= cnt - 8'd1;
            end
            DONE: begin
               rxd   <= ios_c ? sr : '0;
               end_f <= 1'b1;
               cnt   <= HALF_M1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy     = (state != IDLE);
   assign shifting = (state == SHIFT_LO) || (state == SHIFT_HI);

   assign KP_LATCH = (state == LATCH);
   assign KP_CLK   = (state != SHIFT_LO);
   assign KP_OE    = busy & ~ios_c;
   assign KP_DO    = KP_OE & shifting & txd_c[bit_idx];

   assign kpc.RXD  = rxd;
   assign kpc.BUSY = busy;
   assign kpc.END  = end_f;
`ifdef FX_KPORT_INT_EN
   assign kpc.KINT = (state == DONE);
`else
   assign kpc.KINT = 1'b0;
`endif
endmodule

// File: doc/fx_kport.md
# fx_kport

K-Port (keypad) serial transceiver for the PC-FX gate array. It sits directly below the gate array's KPC register interface. It takes the trigger, mode and direction bits written by the CPU and runs the latch/clock/data protocol on one controller port. It returns the 32-bit pad word and a transfer-end flag that the KPC exposes to software, and it can raise the INTKP interrupt source. One instance is used per port; the gate array has two ports.

## Interface
Parameters:
- HALF, 4: CE ticks per half-period of KP_CLK and of each LATCH half (legal range 1–255).
- BITS, 32: bits per transfer (legal range 1–32).

Ports. One clock; reset is synchronous and active-low.
- CLK  in  1  system clock.
- RESn  in  1  synchronous active-low reset.
- CE  in  1  clock enable; all state advances only when CE=1.
- TRG  in  1  one-CE-tick start pulse (the KPC trigger-set bit).
- MOD  in  1  latched at start; 1 = pulse KP_LATCH before shifting, 0 = shift without a latch phase.
- IOS  in  1  latched at start; 1 = receive (KP_OE=0), 0 = transmit (KP_OE=1).
- TXD  in  32  transmit word, sampled at start.
- RD_ACK  in  1  one-tick pulse when the CPU reads the data register; clears END.
- RXD  out  32  last received word (0 after a transmit-only transfer).
- BUSY  out  1  transfer in progress.
- END  out  1  sticky transfer-complete flag.
- KINT  out  1  one-tick interrupt pulse at completion.
- KP_LATCH  out  1  pad latch strobe, active high.
- KP_CLK  out  1  pad shift clock, idles high.
- KP_DI  in  1  serial data from the pad.
- KP_DO  out  1  serial data to the pad.
- KP_OE  out  1  KP_DO drive enable.

## Operation
- States:
  - IDLE: waits for a start.
  - LATCH: pad latch phase.
  - SHIFT_LO: KP_CLK low half of a bit.
  - SHIFT_HI: KP_CLK high half of a bit.
  - DONE: one-tick completion state.
- IDLE + TRG:
  - Capture MOD, IOS and TXD; clear the shift register.
  - Go to LATCH if MOD=1, otherwise go to SHIFT_LO.
- LATCH: KP_LATCH=1 for 2·HALF ticks, then go to SHIFT_LO with bit index 0.
- SHIFT_LO:
  - KP_CLK=0; KP_DO = TXD_captured[bit], LSB first.
  - After HALF ticks, go to SHIFT_HI.
- SHIFT_HI:
  - KP_CLK=1.
  - On entry, sample KP_DI into shift-register bit [bit].
  - After HALF ticks: if bit=BITS−1 go to DONE, else increment bit and go to SHIFT_LO.
- DONE:
  - RXD ← shift register, or 0 if IOS=0.
  - END ← 1; KINT=1 for this tick.
  - Next state is IDLE.
- BUSY=1 in every state except IDLE.
- KP_OE = ~IOS_captured while BUSY, otherwise 0. KP_DO=0 when KP_OE=0.
- Unused RXD bits above BITS read as 0.

## Timing
- Reset values:
  - State IDLE; BUSY, END and KINT 0.
  - RXD 0.
  - KP_LATCH 0, KP_CLK 1, KP_DO 0, KP_OE 0.
- Start latency: TRG at tick t → BUSY=1 and the first phase is visible at tick t+1.
- Transfer length, measured from the first phase to DONE:
  - MOD=1: (2 + 2·BITS)·HALF ticks.
  - MOD=0: 2·BITS·HALF ticks.
  - Defaults, MOD=1: 264 ticks.
- DONE lasts exactly one tick. TRG is accepted again on the next tick.
- Bit counter width is 5 bits. The phase counter is 8 bits and reloads on every state change; no wrap-around is possible within legal parameters.
- Boundary rules:
  - TRG while BUSY: ignored; captured values are unchanged.
  - RD_ACK and DONE in the same tick: END=1, because set wins.
  - RD_ACK while END=0: no effect.
  - TRG in the same tick as RD_ACK: both act independently.
  - CE=0: every register holds, including the phase counter and pins.
  - RESn low mid-transfer: next tick returns to the reset values. RXD is cleared, no KINT is issued, and END stays 0.

## Configuration
- FX_KPORT_INT_EN defined: KINT pulses for one tick in DONE, as described above.
- FX_KPORT_INT_EN undefined: KINT is tied to 0. END, RXD and the rest of the FSM behave identically.

## Test plan
- Reset then idle: hold RESn=0 for 3 ticks, release, idle 10 ticks → BUSY=0, END=0, RXD=0, KP_CLK=1, KP_LATCH=0, KP_OE=0.
- Pad read, defaults: MOD=1, IOS=1, KP_DI driven from the model word 0xA5C3_0F81 LSB first, TRG → KP_LATCH high for 8 ticks, 32 KP_CLK low pulses of 4 ticks each, DONE at tick 264. Then RXD=0xA5C30F81, END=1, KINT pulses once (macro defined).
- Transmit: MOD=0, IOS=0, TXD=0x0000_0003 → KP_OE=1 throughout, KP_DO=1 during bits 0–1 and 0 afterwards, no latch pulse, DONE at tick 256, RXD=0.
- Re-trigger and ack collision: issue TRG at tick 50 of a transfer → the transfer completes unchanged. Then assert RD_ACK in the DONE tick → END=1. A second RD_ACK one tick later → END=0.
- Reset mid-shift: pull RESn low at bit 17 → next tick BUSY=0, KP_CLK=1, RXD=0, no KINT. A fresh TRG then completes normally.
- CE gating with macro undefined: CE toggling 1-of-3 during a default read → same RXD, 792 CLK cycles to DONE, KINT never 1.
